pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_reg_chain.sv | 102 ++++++++++
 tb/tb_pipe_reg_chain.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready register pipeline with per-stage
// flush. Stage 0 takes the upstream item; stage DEPTH-1 drives the outputs.
// With COLLAPSE=1 an empty stage absorbs a stall, so bubbles are squeezed
// out. With COLLAPSE=0 every stage advances only when out_ready is high.
//
// Handshake: an item moves across an interface on a rising clk edge where
// valid and ready are both high. Valid never depends on ready. in_ready is
// built only from out_ready and the stage valid bits. It never depends on
// in_valid or flush. Data is meaningful only while its valid bit is high.
module pipe_reg_chain #(
    parameter int                DATA_W     = 20,
    parameter int                DEPTH      = 3,
    parameter logic [DATA_W-1:0] PRESET_VAL = '0,
    parameter bit                COLLAPSE   = 1'b1
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [DEPTH-1:0]           flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // Per-stage state.
    logic [DEPTH-1:0]  v;
    logic [DATA_W-1:0] d [DEPTH];

    // r[i] = stage i may load this cycle.
    logic [DEPTH-1:0]  r;
    logic              rdy_acc;

    // Item presented to each stage from its upstream neighbour.
    logic [DEPTH-1:0]  up_v;
    logic [DATA_W-1:0] up_d [DEPTH];

    logic [OCC_W-1:0]  occ_sum;

    // Readiness ripples back from out_ready. In collapse mode an empty stage
    // at or after stage i also frees stage i.
    always_comb begin
        rdy_acc = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (COLLAPSE) begin
                rdy_acc = rdy_acc | ~v[i];
            end
            r[i] = rdy_acc;
        end
    end

    // Upstream item for each stage: the input port for stage 0, the previous stage otherwise.
    always_comb begin
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end

    // Stage registers. Flush wins over load. A bubble clears the valid bit
    // but keeps the old data.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                v[i] <= 1'b0;
                d[i] <= PRESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush[i]) begin
                    v[i] <= 1'b0;
                    d[i] <= PRESET_VAL;
                end else if (r[i]) begin
                    v[i] <= up_v[i];
                    if (up_v[i]) begin
                        d[i] <= up_d[i];
                    end
                end
            end
        end
    end

    // Occupancy is the number of valid stages.
    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OCC_W'(v[i]);
        end
    end

    assign in_ready  = r[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: a collapsing instance (index 0) and a lockstep
// instance (index 1) share the same stimulus. A behavioural model of both
// instances is checked against them on every falling edge. An ordered queue
// of accepted items checks delivery order while flush is idle.
module tb_pipe_reg_chain;

    localparam int DW = 8;
    localparam int DP = 3;

    logic          clk;
    logic          arst_n;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic [DP-1:0] flush;

    logic [1:0]    ov;
    logic [1:0]    ir;
    logic [DW-1:0] od [2];
    logic [1:0]    occ [2];

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: [instance][stage].
    logic          mv [2][DP];
    logic [DW-1:0] md [2][DP];

    logic [DW-1:0] exp_q[$];
    bit            sb_en = 1'b0;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs ----------------
    pipe_reg_chain #(.DATA_W(DW), .DEPTH(DP), .PRESET_VAL(8'h00), .COLLAPSE(1'b1)) u_dut (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .occupancy(occ[0])
    );

    pipe_reg_chain #(.DATA_W(DW), .DEPTH(DP), .PRESET_VAL(8'h00), .COLLAPSE(1'b0)) u_dut_lk (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .occupancy(occ[1])
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // A stage may load if downstream accepts. In collapse mode it may also
    // load if any stage from here to the output is empty.
    function automatic logic model_ready(int m, int i);
        if (m == 0) begin
            for (int j = i; j < DP; j++) if (!mv[m][j]) return 1'b1;
        end
        return out_ready;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < DP; i++) begin
                mv[m][i] = 1'b0;
                md[m][i] = 8'h00;
            end
        exp_q.delete();
    endtask

    task automatic model_step();
        logic          nv [2][DP];
        logic [DW-1:0] nd [2][DP];
        logic          uv;
        logic [DW-1:0] ud;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < DP; i++) begin
                nv[m][i] = mv[m][i];
                nd[m][i] = md[m][i];
                if (i == 0) begin
                    uv = in_valid;
                    ud = in_data;
                end else begin
                    uv = mv[m][i-1];
                    ud = md[m][i-1];
                end
                if (flush[i]) begin
                    nv[m][i] = 1'b0;
                    nd[m][i] = 8'h00;
                end else if (model_ready(m, i)) begin
                    nv[m][i] = uv;
                    if (uv) nd[m][i] = ud;
                end
            end
        mv = nv;
        md = nd;
    endtask

    // Model advances on each clock edge; reset clears it at once.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            model_clear();
        end else begin
            if (sb_en && in_valid && model_ready(0, 0)) exp_q.push_back(in_data);
            model_step();
        end
    end

    // Compare both DUTs to the model away from the active edge.
    always @(negedge clk) begin : cmp
        int cnt;
        for (int m = 0; m < 2; m++) begin
            cnt = 0;
            for (int j = 0; j < DP; j++) cnt += int'(mv[m][j]);
            chk($sformatf("m%0d out_valid", m), 32'(ov[m]), 32'(mv[m][DP-1]));
            chk($sformatf("m%0d out_data", m), 32'(od[m]), 32'(md[m][DP-1]));
            chk($sformatf("m%0d occupancy", m), 32'(occ[m]), cnt);
            chk($sformatf("m%0d in_ready", m), 32'(ir[m]), 32'(model_ready(m, 0)));
        end
        if (sb_en && ov[0] && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_underflow: got 0x%0h expected none at %0t", od[0], $time);
            end else begin
                chk("sb_order", 32'(od[0]), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        arst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = '0;
        #2 arst_n = 1'b0;
        step();
        step();
        // Reset values.
        chk("rst out_valid", 32'(ov[0]), 0);
        chk("rst out_data", 32'(od[0]), 32'h00);
        chk("rst occupancy", 32'(occ[0]), 0);
        chk("rst in_ready collapse", 32'(ir[0]), 1);
        chk("rst in_ready lockstep lo", 32'(ir[1]), 0);
        out_ready = 1'b1;
        #1 chk("rst in_ready lockstep hi", 32'(ir[1]), 1);
        step();
        arst_n = 1'b1;

        // Back-to-back stream, latency DEPTH-1 after acceptance.
        in_valid = 1'b1; in_data = 8'h11; step();
        in_data = 8'h22; step();
        in_data = 8'h33; step();
        chk("stream first", 32'(od[0]), 32'h11);
        chk("stream first valid", 32'(ov[0]), 1);
        in_valid = 1'b0; step();
        chk("stream second", 32'(od[0]), 32'h22);
        step();
        chk("stream third", 32'(od[0]), 32'h33);
        step();
        chk("stream drained", 32'(ov[0]), 0);

        // Fill under backpressure, then release.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h01; step();
        in_data = 8'h02; step();
        in_data = 8'h03; step();
        in_data = 8'h04;
        chk("bp in_ready", 32'(ir[0]), 0);
        chk("bp occupancy", 32'(occ[0]), 3);
        step();
        chk("bp hold", 32'(od[0]), 32'h01);
        out_ready = 1'b1; step();
        chk("bp out 02", 32'(od[0]), 32'h02);
        in_valid = 1'b0; step();
        chk("bp out 03", 32'(od[0]), 32'h03);
        step();
        chk("bp out 04", 32'(od[0]), 32'h04);
        step();
        chk("bp empty", 32'(occ[0]), 0);

        // Flush the middle stage while the output drains.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hCC; step();
        in_data = 8'hBB; step();
        in_data = 8'hAA; step();
        chk("fl pre out", 32'(od[0]), 32'hCC);
        out_ready = 1'b1; flush = 3'b010; in_data = 8'h55; step();
        chk("fl stage2", 32'(od[0]), 32'hBB);
        chk("fl occupancy", 32'(occ[0]), 2);
        flush = '0; in_valid = 1'b0; step();
        chk("fl bubble", 32'(ov[0]), 0);
        step();
        chk("fl stage0 item", 32'(od[0]), 32'h55);

        // Empty pipe under backpressure: lockstep refuses, collapse advances.
        do_reset();
        out_ready = 1'b0;
        #1 chk("lk empty in_ready", 32'(ir[1]), 0);
        in_valid = 1'b1; in_data = 8'h77; step();
        in_valid = 1'b0; step();
        step();
        chk("col 77 at out", 32'(od[0]), 32'h77);
        chk("col occupancy", 32'(occ[0]), 1);
        chk("lk occupancy", 32'(occ[1]), 0);

        // Mid-cycle reset with a full pipe.
        do_reset();
        in_valid = 1'b1;
        repeat (3) begin
            in_data = 8'($urandom_range(1, 255));
            step();
        end
        chk("mid full", 32'(occ[0]), 3);
        #2 arst_n = 1'b0;
        #1;
        chk("mid out_valid", 32'(ov[0]), 0);
        chk("mid occupancy", 32'(occ[0]), 0);
        chk("mid out_data", 32'(od[0]), 32'h00);
        step();
        arst_n = 1'b1;
        out_ready = 1'b1; in_data = 8'h09; step();
        in_valid = 1'b0; step();
        step();
        chk("post rst latency", 32'(od[0]), 32'h09);
        chk("post rst valid", 32'(ov[0]), 1);

        // Random traffic, no flush, ordered delivery tracked.
        do_reset();
        sb_en = 1'b1;
        repeat (300) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        chk("sb drained", exp_q.size(), 0);
        sb_en = 1'b0;

        // Random traffic with random flushes.
        repeat (300) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step();
        end
        flush = '0; in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
